hazard_unit: RTL and testbench

Pipeline interlock and branch-squash controller for the 16-bit, 4-register, 3-stage (IF/ID/EX) CPU. It sits beside the ID stage and decodes the instruction in IFID. A per-register scoreboard tracks pending writebacks. The block stalls PC/IFID, injects bubbles into IDEX, and flushes IFID on a taken branch, which removes the hand-inserted nops from programs. With forwarding compiled in, it also drives the EX operand-bypass selects.

---
 rtl/hazard_unit_if.sv | 47 ++++
 rtl/hazard_unit.sv | 200 ++++++++++++++++++++
 tb/tb_hazard_unit.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_if.sv
// -----------------------------------------------------------------------------
// hazard_unit_if
// Bundles the ID-stage decode inputs, the EX branch-taken strobe and all of the
// interlock/flush/bypass outputs exchanged between the pipeline and hazard_unit.
//
//   id_valid         IFID holds a real instruction
//   id_op            IFID_IR[15:12]
//   id_rs/rt/rd      IFID_IR[11:10] / [9:8] / [7:6]
//   ex_branch_taken  branch in EX resolved taken
//   pc_write         PC loads NextPC
//   ifid_write       IFID loads the fetched instruction
//   idex_bubble      IDEX loads all-zero control
//   ifid_flush       IFID loads 16'h0000
//   fwd_a / fwd_b    ALU operand source: 00 = IDEX_RD, 01 = EX ALUOut
//   state            00 RUN, 01 STALL, 10 FLUSH
//   stall_count      saturating count of hazard-stall cycles
//
// master = pipeline side, slave = hazard_unit.
// -----------------------------------------------------------------------------
interface hazard_unit_if;
    logic        id_valid;
    logic [3:0]  id_op;
    logic [1:0]  id_rs;
    logic [1:0]  id_rt;
    logic [1:0]  id_rd;
    logic        ex_branch_taken;
    logic        pc_write;
    logic        ifid_write;
    logic        idex_bubble;
    logic        ifid_flush;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [1:0]  state;
    logic [15:0] stall_count;

    modport master (
        output id_valid, id_op, id_rs, id_rt, id_rd, ex_branch_taken,
        input  pc_write, ifid_write, idex_bubble, ifid_flush,
               fwd_a, fwd_b, state, stall_count
    );

    modport slave (
        input  id_valid, id_op, id_rs, id_rt, id_rd, ex_branch_taken,
        output pc_write, ifid_write, idex_bubble, ifid_flush,
               fwd_a, fwd_b, state, stall_count
    );
endinterface

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
// Pipeline interlock and branch-squash controller for the 3-stage IF/ID/EX CPU.
// Decodes the instruction in IFID, tracks pending register writebacks in a
// per-register down-counter scoreboard, stalls PC/IFID and bubbles IDEX on a
// RAW hazard, and flushes IFID when the branch in EX is taken.
//
// Ports:
//   i_clock  pipeline clock; all state changes on the falling edge
//   i_reset  asynchronous, active-high
//   hz       hazard_unit_if.slave (decode inputs, control outputs)
//
// Parameters:
//   WB_LAT    cycles from a producer entering EX until its result is readable
//             from the register file (1..3)
//   LW_EXTRA  extra pending cycles for LW
//
// Optional feature macro: HAZARD_FWD_EN
//   defined   : a producer currently in EX (counter == WB_LAT) is bypassed via
//               fwd_x = 01; only an LW still in its extra cycles stalls; older
//               pending writes come from the register-file write path.
//   undefined : fwd_a = fwd_b = 00 and every pending source stalls.
//
// state | meaning
// ------+----------------------------------------------------------------
// RUN   | normal issue; hazards checked every cycle
// STALL | ID instruction held on a RAW hazard; IDEX receiving bubbles
// FLUSH | IFID holds the squashed nop; hazard checking suppressed
// -----------------------------------------------------------------------------
module hazard_unit #(
    parameter int WB_LAT   = 2,
    parameter int LW_EXTRA = 1
) (
    input  logic          i_clock,
    input  logic          i_reset,
    hazard_unit_if.slave  hz
);

    localparam int CNT_MAX = WB_LAT + LW_EXTRA;
    // counters sized to hold the longest (LW) pending window
    localparam int CW = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] C_WB = CW'(WB_LAT);
    localparam logic [CW-1:0] C_LW = CW'(CNT_MAX);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0][CW-1:0]    r_sb;        // entry 0 is $0 and stays zero
    logic [15:0]           r_stall_count;

    logic                  w_rd_rs;
    logic                  w_rd_rt;
    logic                  w_dst_en;
    logic [1:0]            w_dst;
    logic                  w_is_lw;
    logic [CW-1:0]         w_cnt_rs;
    logic [CW-1:0]         w_cnt_rt;
    logic                  w_blk_rs;
    logic                  w_blk_rt;
    logic                  w_fwd_rs;
    logic                  w_fwd_rt;
    logic                  w_hazard;
    logic                  w_issue;

    // ---------------- decode ----------------
    always_comb begin
        w_rd_rs  = 1'b0;
        w_rd_rt  = 1'b0;
        w_dst_en = 1'b0;
        w_dst    = 2'd0;
        w_is_lw  = 1'b0;
        case (hz.id_op)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111: begin
                w_rd_rs  = 1'b1;
                w_rd_rt  = 1'b1;
                w_dst_en = 1'b1;
                w_dst    = hz.id_rd;
            end
            4'b0110, 4'b1000, 4'b1001: begin
                w_rd_rs = 1'b1;
                w_rd_rt = 1'b1;
            end
            4'b0100: begin
                w_rd_rs  = 1'b1;
                w_dst_en = 1'b1;
                w_dst    = hz.id_rt;
            end
            4'b0101: begin
                w_rd_rs  = 1'b1;
                w_dst_en = 1'b1;
                w_dst    = hz.id_rt;
                w_is_lw  = 1'b1;
            end
            default: ;
        endcase
        // $0 is hard-wired, so a write to it never becomes pending
        if (w_dst == 2'd0)
            w_dst_en = 1'b0;
    end

    assign w_cnt_rs = r_sb[hz.id_rs];
    assign w_cnt_rt = r_sb[hz.id_rt];

`ifdef HAZARD_FWD_EN
    // above WB_LAT only an LW in its extra cycles; at WB_LAT the producer is in EX
    assign w_blk_rs = w_rd_rs && (w_cnt_rs > C_WB);
    assign w_blk_rt = w_rd_rt && (w_cnt_rt > C_WB);
    assign w_fwd_rs = w_rd_rs && (w_cnt_rs == C_WB);
    assign w_fwd_rt = w_rd_rt && (w_cnt_rt == C_WB);
`else
    assign w_blk_rs = w_rd_rs && (w_cnt_rs != '0);
    assign w_blk_rt = w_rd_rt && (w_cnt_rt != '0);
    assign w_fwd_rs = 1'b0;
    assign w_fwd_rt = 1'b0;
`endif

    assign w_hazard = hz.id_valid && (r_state != ST_FLUSH) && (w_blk_rs || w_blk_rt);
    assign w_issue  = hz.id_valid && !w_hazard && !hz.ex_branch_taken;

    // ---------------- combinational control outputs ----------------
    always_comb begin
        hz.pc_write    = 1'b1;
        hz.ifid_write  = 1'b1;
        hz.idex_bubble = 1'b0;
        hz.ifid_flush  = 1'b0;
        hz.fwd_a       = 2'b00;
        hz.fwd_b       = 2'b00;
        // reset forces the idle pattern even while a branch strobe is present
        if (!i_reset) begin
            if (hz.ex_branch_taken) begin
                hz.ifid_flush  = 1'b1;
                hz.idex_bubble = 1'b1;
            end else if (w_hazard) begin
                hz.pc_write    = 1'b0;
                hz.ifid_write  = 1'b0;
                hz.idex_bubble = 1'b1;
            end else begin
                if (w_issue && w_fwd_rs)
                    hz.fwd_a = 2'b01;
                if (w_issue && w_fwd_rt)
                    hz.fwd_b = 2'b01;
            end
        end
    end

    // ---------------- FSM ----------------
    always_comb begin
        w_state_nxt = r_state;
        if (hz.ex_branch_taken)
            w_state_nxt = ST_FLUSH;
        else begin
            case (r_state)
                ST_RUN:   w_state_nxt = w_hazard ? ST_STALL : ST_RUN;
                ST_STALL: w_state_nxt = w_hazard ? ST_STALL : ST_RUN;
                ST_FLUSH: w_state_nxt = ST_RUN;
                default:  w_state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(negedge i_clock or posedge i_reset) begin
        if (i_reset)
            r_state <= ST_RUN;
        else
            r_state <= w_state_nxt;
    end

    // ---------------- scoreboard ----------------
    always_ff @(negedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_sb <= '0;
        end else begin
            r_sb[0] <= '0;
            for (int i = 1; i < 4; i++) begin
                // a new issue to the same register wins over the decrement
                if (w_issue && w_dst_en && (w_dst == 2'(i)))
                    r_sb[i] <= w_is_lw ? C_LW : C_WB;
                else if (r_sb[i] != '0)
                    r_sb[i] <= r_sb[i] - 1'b1;
            end
        end
    end

    // ---------------- stall counter ----------------
    always_ff @(negedge i_clock or posedge i_reset) begin
        if (i_reset)
            r_stall_count <= 16'h0000;
        else if (w_hazard && !hz.ex_branch_taken && (r_stall_count != 16'hFFFF))
            r_stall_count <= r_stall_count + 16'h0001;
    end

    assign hz.state       = r_state;
    assign hz.stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
// Directed-vector bench for hazard_unit (WB_LAT=2, LW_EXTRA=1). Inputs change
// just after the falling edge; combinational outputs are sampled at the rising
// edge and registered outputs just after the falling edge. Expected values
// follow HAZARD_FWD_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_hazard_unit;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_LW   = 4'b0101;
    localparam logic [3:0] OP_BEQ  = 4'b1000;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        rst;
    int          n_checks;
    int          n_errors;
    logic [15:0] exp_cnt;

    hazard_unit_if hz ();

    hazard_unit #(
        .WB_LAT   (2),
        .LW_EXTRA (1)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .hz      (hz)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [1:0] rs,
                         input logic [1:0] rt, input logic [1:0] rd, input logic br);
        hz.id_valid        = v;
        hz.id_op           = op;
        hz.id_rs           = rs;
        hz.id_rt           = rt;
        hz.id_rd           = rd;
        hz.ex_branch_taken = br;
    endtask

    task automatic adv();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 4'h0, 2'd0, 2'd0, 2'd0, 1'b0);
        repeat (n) adv();
    endtask

    // producer that must issue immediately
    task automatic issue(input string tag, input logic [3:0] op, input logic [1:0] rs,
                         input logic [1:0] rt, input logic [1:0] rd);
        drive(1'b1, op, rs, rt, rd, 1'b0);
        @(posedge clk);
        check_val({tag, ".issue_pcw"}, hz.pc_write, 1'b1);
        adv();
    endtask

    // consumer already driven: expect n stall cycles, then issue with fa/fb
    task automatic expect_stalls(input string tag, input int n,
                                 input logic [1:0] fa, input logic [1:0] fb);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            check_val({tag, ".stall_pcw"},  hz.pc_write,    1'b0);
            check_val({tag, ".stall_ifw"},  hz.ifid_write,  1'b0);
            check_val({tag, ".stall_bub"},  hz.idex_bubble, 1'b1);
            adv();
            if (exp_cnt != 16'hFFFF)
                exp_cnt = exp_cnt + 16'd1;
            check_val({tag, ".stall_state"}, hz.state,       2'b01);
            check_val({tag, ".stall_cnt"},   hz.stall_count, exp_cnt);
        end
        @(posedge clk);
        check_val({tag, ".go_pcw"},  hz.pc_write,    1'b1);
        check_val({tag, ".go_bub"},  hz.idex_bubble, 1'b0);
        check_val({tag, ".go_fwda"}, hz.fwd_a,       fa);
        check_val({tag, ".go_fwdb"}, hz.fwd_b,       fb);
        adv();
        check_val({tag, ".go_state"}, hz.state,       2'b00);
        check_val({tag, ".go_cnt"},   hz.stall_count, exp_cnt);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_cnt  = 16'h0000;
        rst      = 1'b1;
        drive(1'b0, 4'h0, 2'd0, 2'd0, 2'd0, 1'b0);

        // reset values
        #12;
        check_val("rst.state", hz.state,       2'b00);
        check_val("rst.cnt",   hz.stall_count, 16'h0000);
        check_val("rst.pcw",   hz.pc_write,    1'b1);
        check_val("rst.ifw",   hz.ifid_write,  1'b1);
        check_val("rst.bub",   hz.idex_bubble, 1'b0);
        check_val("rst.flush", hz.ifid_flush,  1'b0);
        check_val("rst.fwd",   {hz.fwd_a, hz.fwd_b}, 4'b0000);
        rst = 1'b0;
        adv();

        // addi $1,$0,15 ; and $3,$1,$2 back-to-back
        issue("t1", OP_ADDI, 2'd0, 2'd1, 2'd0);
        drive(1'b1, OP_AND, 2'd1, 2'd2, 2'd3, 1'b0);
        expect_stalls("t1", FWD ? 0 : 2, FWD ? 2'b01 : 2'b00, 2'b00);
        idle(4);

        // dependent instruction one slot behind its producer
        issue("t2a", OP_ADDI, 2'd0, 2'd1, 2'd0);
        issue("t2b", OP_ADD,  2'd0, 2'd0, 2'd2);
        drive(1'b1, OP_AND, 2'd1, 2'd1, 2'd3, 1'b0);
        expect_stalls("t2", FWD ? 0 : 1, 2'b00, 2'b00);
        idle(4);

        // lw $1 ; add $2,$1,$1
        issue("t3", OP_LW, 2'd0, 2'd1, 2'd0);
        drive(1'b1, OP_ADD, 2'd1, 2'd1, 2'd2, 1'b0);
        expect_stalls("t3", FWD ? 1 : 3, FWD ? 2'b01 : 2'b00, FWD ? 2'b01 : 2'b00);
        idle(4);

        // writes to $0 never become pending
        issue("t4", OP_ADDI, 2'd0, 2'd0, 2'd0);
        drive(1'b1, OP_ADD, 2'd0, 2'd0, 2'd1, 1'b0);
        expect_stalls("t4", 0, 2'b00, 2'b00);
        idle(4);

        // taken branch while the ID instruction is stalled
        issue("t5", OP_LW, 2'd0, 2'd1, 2'd0);
        drive(1'b1, OP_AND, 2'd1, 2'd1, 2'd3, 1'b0);
        @(posedge clk);
        check_val("t5.pre_pcw", hz.pc_write, 1'b0);
        adv();
        exp_cnt = exp_cnt + 16'd1;
        check_val("t5.pre_state", hz.state, 2'b01);
        drive(1'b1, OP_AND, 2'd1, 2'd1, 2'd3, 1'b1);
        @(posedge clk);
        check_val("t5.br_flush", hz.ifid_flush,  1'b1);
        check_val("t5.br_bub",   hz.idex_bubble, 1'b1);
        check_val("t5.br_pcw",   hz.pc_write,    1'b1);
        adv();
        check_val("t5.fl_state", hz.state,       2'b10);
        check_val("t5.fl_cnt",   hz.stall_count, exp_cnt);
        drive(1'b0, OP_BEQ, 2'd0, 2'd0, 2'd0, 1'b0);
        @(posedge clk);
        check_val("t5.fl_flush", hz.ifid_flush, 1'b0);
        adv();
        check_val("t5.run_state", hz.state,       2'b00);
        check_val("t5.run_cnt",   hz.stall_count, exp_cnt);
        // squashed "and $3" must not have made $3 pending
        drive(1'b1, OP_AND, 2'd3, 2'd3, 2'd2, 1'b0);
        expect_stalls("t5rd3", 0, 2'b00, 2'b00);
        idle(4);

        // saturation from 16'hFFFE
        @(posedge clk);
        force dut.r_stall_count = 16'hFFFE;
        #1;
        release dut.r_stall_count;
        exp_cnt = 16'hFFFE;
        adv();
        issue("t6a", OP_LW, 2'd0, 2'd1, 2'd0);
        drive(1'b1, OP_ADD, 2'd1, 2'd1, 2'd2, 1'b0);
        expect_stalls("t6a", FWD ? 1 : 3, FWD ? 2'b01 : 2'b00, FWD ? 2'b01 : 2'b00);
        issue("t6b", OP_LW, 2'd0, 2'd1, 2'd0);
        drive(1'b1, OP_ADD, 2'd1, 2'd1, 2'd2, 1'b0);
        expect_stalls("t6b", FWD ? 1 : 3, FWD ? 2'b01 : 2'b00, FWD ? 2'b01 : 2'b00);
        check_val("t6.sat", hz.stall_count, 16'hFFFF);
        idle(4);

        // reset pulsed mid-STALL
        issue("t7", OP_LW, 2'd0, 2'd1, 2'd0);
        drive(1'b1, OP_ADD, 2'd1, 2'd1, 2'd2, 1'b0);
        @(posedge clk);
        check_val("t7.pre_pcw", hz.pc_write, 1'b0);
        adv();
        check_val("t7.pre_state", hz.state, 2'b01);
        #2;
        rst = 1'b1;
        #1;
        check_val("t7.rst_pcw",   hz.pc_write,    1'b1);
        check_val("t7.rst_ifw",   hz.ifid_write,  1'b1);
        check_val("t7.rst_bub",   hz.idex_bubble, 1'b0);
        check_val("t7.rst_state", hz.state,       2'b00);
        check_val("t7.rst_cnt",   hz.stall_count, 16'h0000);
        #1;
        rst = 1'b0;
        exp_cnt = 16'h0000;
        expect_stalls("t7post", 0, 2'b00, 2'b00);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
